// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_state_e : fetch sequencer state (bubble after reset, run, halted, fault)
//   fetch_act_e   : action chosen by next_pc_calc for the current RUN edge
//   HALT_OP       : opcode that halts fetch
//   BUBBLE_WORD   : word instruction memory presents for the -4 reset address
//   RESET_ADDR    : fetch address / fetch PC after reset
package cpu_pkg;

  typedef enum logic [1:0] {
    StBubble,
    StRun,
    StHalted,
    StFault
  } fetch_state_e;

  typedef enum logic [2:0] {
    ActAdvance,
    ActStall,
    ActRedirect,
    ActHalt,
    ActFault
  } fetch_act_e;

  localparam logic [5:0]  HALT_OP     = 6'b111111;
  localparam logic [31:0] BUBBLE_WORD = 32'hFC00_0000;
  localparam logic [31:0] RESET_ADDR  = 32'hFFFF_FFFC;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-fetch-address selection for fetch_pc_unit.
// Resolves halt > stall > jump-register > jump > branch > sequential advance and
// computes the redirect targets, all masked into the instruction memory range.
// Build option: FETCH_MISALIGN_TRAP_EN turns a misaligned jump-register target into
// ActFault instead of silently clearing the low two bits.
// Ports:
//   valid_i, stall_hold_i   current word valid / previous edge entered a stall replay
//   stall_i, branch_*, jump_*, *reg*  decoder redirect and stall requests
//   instr_op_i              opcode field of the word memory presents
//   addr_i, fetch_pc_i, pc_plus4_i  current fetch address, its predecessor, and +4
//   action_o, next_addr_o   chosen action and the address to drive next
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int unsigned ImemBytes = 512,
  parameter logic [5:0]  HaltOp    = 6'b111111
) (
  input  logic        valid_i,
  input  logic        stall_hold_i,
  input  logic        stall_i,
  input  logic [5:0]  instr_op_i,
  input  logic        jump_reg_i,
  input  logic [31:0] reg_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_offset_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [31:0] pc_plus4_i,
  output fetch_act_e  action_o,
  output logic [31:0] next_addr_o
);

  localparam logic [31:0] AddrMask = 32'(ImemBytes - 1);

  logic [31:0] seq_addr;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;

  assign seq_addr  = (addr_i + 32'd4) & AddrMask;
  assign br_target = (pc_plus4_i + {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00}) & AddrMask;
  assign j_target  = {pc_plus4_i[31:28], jump_target_i, 2'b00} & AddrMask;
  assign jr_target = {reg_target_i[31:2], 2'b00} & AddrMask;

`ifndef FETCH_MISALIGN_TRAP_EN
  // Low target bits are dropped without a trap in this build.
  logic unused_reg_target_lsbs;
  assign unused_reg_target_lsbs = ^reg_target_i[1:0];
`endif

  always_comb begin
    action_o    = ActAdvance;
    next_addr_o = seq_addr;
    if (valid_i) begin
      if (instr_op_i == HaltOp) begin
        action_o    = ActHalt;
        next_addr_o = addr_i;
      end else if (stall_i) begin
        // Replay: refetch the word currently being presented.
        action_o    = ActStall;
        next_addr_o = fetch_pc_i;
      end else if (jump_reg_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (reg_target_i[1:0] != 2'b00) begin
          action_o    = ActFault;
          next_addr_o = addr_i;
        end else
`endif
        begin
          action_o    = ActRedirect;
          next_addr_o = jr_target;
        end
      end else if (jump_i) begin
        action_o    = ActRedirect;
        next_addr_o = j_target;
      end else if (branch_taken_i) begin
        action_o    = ActRedirect;
        next_addr_o = br_target;
      end
    end else if (stall_hold_i && stall_i) begin
      // Stall still asserted while replaying: keep the replay address parked.
      action_o    = ActStall;
      next_addr_o = fetch_pc_i;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer in front of a registered instruction memory.
// Drives o_Addr, tracks the address of the word memory presents (o_Fetch_PC) and marks
// that word valid for the decoder. Handles redirects, stall replay and halt.
// Build option: FETCH_MISALIGN_TRAP_EN enables the FAULT state / o_Fault on a
// misaligned jump-register target; otherwise o_Fault is tied low.
// Ports:
//   i_Clk, i_Rst                      clock, synchronous active-high reset
//   i_Stall                           hazard stall (replays the current word)
//   i_Branch_Taken/i_Branch_Offset    taken branch, signed word offset
//   i_Jump/i_Jump_Target              J/JAL, 26-bit target field
//   i_Jump_Reg/i_Reg_Target           JR/JALR, register target
//   i_Instruction                     word from instruction memory
//   o_Addr, o_Fetch_PC, o_PC_Plus4    fetch address, address of i_Instruction, +4
//   o_Valid, o_Halted, o_Fault        word valid, halt reached, misaligned target trap
module fetch_pc_unit #(
  parameter int unsigned IMEM_BYTES = 512,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Stall,
  input  logic        i_Branch_Taken,
  input  logic [15:0] i_Branch_Offset,
  input  logic        i_Jump,
  input  logic [25:0] i_Jump_Target,
  input  logic        i_Jump_Reg,
  input  logic [31:0] i_Reg_Target,
  input  logic [31:0] i_Instruction,
  output logic [31:0] o_Addr,
  output logic [31:0] o_Fetch_PC,
  output logic [31:0] o_PC_Plus4,
  output logic        o_Valid,
  output logic        o_Halted,
  output logic        o_Fault
);

  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         stall_hold_q, stall_hold_d;
  fetch_act_e   action;
  logic [31:0]  next_addr;
  logic [31:0]  pc_plus4;

  logic unused_instr_low;
  assign unused_instr_low = ^i_Instruction[25:0];

  assign pc_plus4 = fetch_pc_q + 32'd4;

  next_pc_calc #(
    .ImemBytes(IMEM_BYTES),
    .HaltOp   (HALT_OP)
  ) u_next_pc_calc (
    .valid_i        (valid_q),
    .stall_hold_i   (stall_hold_q),
    .stall_i        (i_Stall),
    .instr_op_i     (i_Instruction[31:26]),
    .jump_reg_i     (i_Jump_Reg),
    .reg_target_i   (i_Reg_Target),
    .jump_i         (i_Jump),
    .jump_target_i  (i_Jump_Target),
    .branch_taken_i (i_Branch_Taken),
    .branch_offset_i(i_Branch_Offset),
    .addr_i         (addr_q),
    .fetch_pc_i     (fetch_pc_q),
    .pc_plus4_i     (pc_plus4),
    .action_o       (action),
    .next_addr_o    (next_addr)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fetch_pc_d   = fetch_pc_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    stall_hold_d = stall_hold_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d      = fault_q;
`endif
    unique case (state_q)
      StBubble: begin
        // Memory latches the -4 bubble word on this edge, so valid stays low.
        addr_d  = 32'd0;
        valid_d = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        unique case (action)
          ActAdvance: begin
            fetch_pc_d   = addr_q;
            addr_d       = next_addr;
            valid_d      = 1'b1;
            stall_hold_d = 1'b0;
          end
          ActRedirect: begin
            // The word latched this edge is wrong-path; flush it.
            fetch_pc_d   = addr_q;
            addr_d       = next_addr;
            valid_d      = 1'b0;
            stall_hold_d = 1'b0;
          end
          ActStall: begin
            addr_d       = next_addr;
            valid_d      = 1'b0;
            stall_hold_d = 1'b1;
          end
          ActHalt: begin
            state_d  = StHalted;
            halted_d = 1'b1;
            valid_d  = 1'b0;
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          ActFault: begin
            state_d = StFault;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      // Halted and fault states hold everything until reset.
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= StBubble;
      addr_q       <= RESET_ADDR;
      fetch_pc_q   <= RESET_ADDR;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      stall_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fetch_pc_q   <= fetch_pc_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      stall_hold_q <= stall_hold_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign o_Fault = fault_q;
`else
  assign o_Fault = 1'b0;
`endif

  assign o_Addr     = addr_q;
  assign o_Fetch_PC = fetch_pc_q;
  assign o_PC_Plus4 = pc_plus4;
  assign o_Valid    = valid_q;
  assign o_Halted   = halted_q;

endmodule
